tdm_demux: RTL and testbench



---
 rtl/tdm_demux_pkg.sv | 18 +
 rtl/tdm_slot_ctr.sv | 35 +++
 rtl/tdm_demux.sv | 133 +++++++++++++
 tb/tb_tdm_demux.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared types, default widths and counter sizing for tdm_demux
package tdm_demux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PAR
    } state_t;

    localparam int DEF_NCH = 4;
    localparam int DEF_W   = 8;

    // A single-slot frame still needs a one-bit counter.
    function automatic int ctr_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - slot index within the frame being collected
module tdm_slot_ctr
    import tdm_demux_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CW  = ctr_width(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic          i_load1,
    output logic [CW-1:0] o_slot,
    output logic          o_last
);

    logic [CW-1:0] r_slot;

    // A new start-of-frame wins over everything else: slot 0 is the sof beat itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_load1) begin
            r_slot <= CW'(1);
        end else if (i_clr) begin
            r_slot <= '0;
        end else if (i_inc) begin
            r_slot <= r_slot + CW'(1);
        end
    end

    assign o_slot = r_slot;
    assign o_last = (r_slot == CW'(NCH - 1));

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM slot stream to parallel channel demultiplexer
// Defining TDM_DEMUX_PARITY_EN adds a trailing even-parity beat to every frame.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int W   = DEF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [W-1:0]     in_data,
    output logic [NCH*W-1:0] out_data,
    output logic             out_valid,
    output logic             out_err
);

    localparam int CW = ctr_width(NCH);

    state_t           r_state;
    logic [NCH*W-1:0] r_shadow;
    logic [NCH*W-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_err;

    logic [NCH*W-1:0] w_next_shadow;
    logic [CW-1:0]    w_slot;
    logic [CW-1:0]    w_wr_slot;
    logic             w_last;
    logic             w_sof_beat;
    logic             w_data_beat;
    logic             w_clr;
    logic             w_inc;
    logic             w_load1;

    assign w_sof_beat  = in_valid && in_sof;
    assign w_data_beat = in_valid && !in_sof && (r_state == COLLECT);
    assign w_load1     = w_sof_beat && (NCH > 1);
    assign w_clr       = (w_sof_beat && (NCH == 1)) || (w_data_beat && w_last);
    assign w_inc       = w_data_beat && !w_last;
    assign w_wr_slot   = in_sof ? '0 : w_slot;

    tdm_slot_ctr #(
        .NCH (NCH),
        .CW  (CW)
    ) u_slot_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .i_load1 (w_load1),
        .o_slot  (w_slot),
        .o_last  (w_last)
    );

    // Shadow with the current beat merged in, so a completing beat lands in out_data directly.
    always_comb begin
        w_next_shadow = r_shadow;
        for (int k = 0; k < NCH; k++) begin
            if (w_wr_slot == CW'(k)) begin
                w_next_shadow[k*W +: W] = in_data;
            end
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic w_par;
    assign w_par = ^r_shadow;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shadow    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            if (w_sof_beat) begin
                r_out_err <= (r_state != IDLE);
                r_shadow  <= w_next_shadow;
                if (NCH == 1) begin
`ifdef TDM_DEMUX_PARITY_EN
                    r_state <= PAR;
`else
                    r_out_data  <= w_next_shadow;
                    r_out_valid <= 1'b1;
                    r_state     <= IDLE;
`endif
                end else begin
                    r_state <= COLLECT;
                end
            end else if (in_valid) begin
                case (r_state)
                    IDLE: begin
                        r_out_err <= 1'b1;
                    end
                    COLLECT: begin
                        r_shadow <= w_next_shadow;
                        if (w_last) begin
`ifdef TDM_DEMUX_PARITY_EN
                            r_state <= PAR;
`else
                            r_out_data  <= w_next_shadow;
                            r_out_valid <= 1'b1;
                            r_state     <= IDLE;
`endif
                        end
                    end
                    default: begin
`ifdef TDM_DEMUX_PARITY_EN
                        if (w_par == in_data[0]) begin
                            r_out_data  <= r_shadow;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_out_err <= 1'b1;
                        end
`endif
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed and random checks of tdm_demux against a frame-queue model
module tb_tdm_demux;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_sof;
    logic [W-1:0]     in_data;
    logic [NCH*W-1:0] out_data;
    logic             out_valid;
    logic             out_err;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]     q[$];
    bit               m_par;
    logic [NCH*W-1:0] exp_data;

    tdm_demux #(
        .NCH (NCH),
        .W   (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NCH*W-1:0] obs, input logic [NCH*W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [NCH*W-1:0] pack_frame();
        logic [NCH*W-1:0] f = '0;
        for (int k = 0; k < NCH; k++) f[k*W +: W] = q[k];
        return f;
    endfunction

    function automatic bit frame_parity();
        bit p = 1'b0;
        for (int k = 0; k < NCH; k++)
            for (int b = 0; b < W; b++) p = p ^ q[k][b];
        return p;
    endfunction

    // Drive one cycle of input, then compare outputs against the frame model.
    task automatic step(input bit v, input bit sof, input logic [W-1:0] d);
        bit ev = 1'b0;
        bit ee = 1'b0;
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        @(negedge clk);
        if (v) begin
            if (sof) begin
                ee = (q.size() != 0) || m_par;
                q.delete();
                m_par = 1'b0;
                q.push_back(d);
            end else if (m_par) begin
                if (frame_parity() == d[0]) begin
                    exp_data = pack_frame();
                    ev = 1'b1;
                end else begin
                    ee = 1'b1;
                end
                q.delete();
                m_par = 1'b0;
            end else if (q.size() == 0) begin
                ee = 1'b1;
            end else begin
                q.push_back(d);
            end
            if (q.size() == NCH && !m_par) begin
`ifdef TDM_DEMUX_PARITY_EN
                m_par = 1'b1;
`else
                exp_data = pack_frame();
                ev = 1'b1;
                q.delete();
`endif
            end
        end
        check("out_valid", {{(NCH*W-1){1'b0}}, out_valid}, {{(NCH*W-1){1'b0}}, ev});
        check("out_err", {{(NCH*W-1){1'b0}}, out_err}, {{(NCH*W-1){1'b0}}, ee});
        check("out_data", out_data, exp_data);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom));
    endtask

    task automatic model_reset();
        q.delete();
        m_par    = 1'b0;
        exp_data = '0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_data", out_data, '0);
        check("reset_valid", {{(NCH*W-1){1'b0}}, out_valid}, '0);
        check("reset_err", {{(NCH*W-1){1'b0}}, out_err}, '0);
        rst = 1'b0;

        step(1, 1, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
`ifdef TDM_DEMUX_PARITY_EN
        step(1, 0, 8'h00);
`else
        check("frame1_const", out_data, 32'h44332211);
`endif
        gap(1);

        step(1, 1, 8'h11); gap(2); step(1, 0, 8'h22); gap(2);
        step(1, 0, 8'h33); gap(2); step(1, 0, 8'h44);
`ifdef TDM_DEMUX_PARITY_EN
        step(1, 0, 8'h00);
`endif
        step(1, 1, 8'hA1); step(1, 0, 8'hA2); step(1, 0, 8'hA3); step(1, 0, 8'hA4);
`ifdef TDM_DEMUX_PARITY_EN
        step(1, 0, 8'h00);
`else
        check("frame_a_const", out_data, 32'hA4A3A2A1);
`endif

        step(1, 1, 8'hAA); step(1, 0, 8'hBB); step(1, 1, 8'hCC);
        step(1, 0, 8'hDD); step(1, 0, 8'hEE); step(1, 0, 8'hFF);
`ifdef TDM_DEMUX_PARITY_EN
        step(1, 0, 8'h00);
`else
        check("restart_const", out_data, 32'hFFEEDDCC);
`endif

        step(1, 0, 8'h55);
        gap(1);

        step(1, 1, 8'h10); step(1, 0, 8'h20);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_data", out_data, '0);
        check("async_rst_valid", {{(NCH*W-1){1'b0}}, out_valid}, '0);
        check("async_rst_err", {{(NCH*W-1){1'b0}}, out_err}, '0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 8'h01); step(1, 0, 8'h02); step(1, 0, 8'h03); step(1, 0, 8'h04);
`ifdef TDM_DEMUX_PARITY_EN
        step(1, 0, 8'h01);
        step(1, 1, 8'h01); step(1, 0, 8'h02); step(1, 0, 8'h03); step(1, 0, 8'h04);
        step(1, 0, 8'h00);
`else
        check("post_rst_const", out_data, 32'h04030201);
`endif

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3) != 0, $urandom_range(4) == 0, W'($urandom));
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
